// File: rtl/bram_arb_pkg.sv
// Shared types for the two-port block RAM arbiter.
package bram_arb_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } bram_port_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } clr_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: same-cycle one-hot grant, priority flips to the
// other port after every grant and holds otherwise.
module rr_arb2
  import bram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  bram_port_t r_prio;
  logic [1:0] w_req;

  always_comb begin
    w_req = req & {2{en}};
    gnt   = 2'b00;
    case (w_req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (r_prio == PORT_A) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= PORT_A;
    end else if (gnt[0]) begin
      r_prio <= PORT_B;
    end else if (gnt[1]) begin
      r_prio <= PORT_A;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one read-first single-port block RAM between requesters A and B.
// Define BRAM_ARB_CLEAR_EN to zero the whole RAM after reset before serving requests.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter  int unsigned abits  = 8,
  parameter  int unsigned dbytes = 4,
  parameter  int unsigned blen   = 8,
  localparam int unsigned dbits  = dbytes * blen
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [dbytes-1:0] a_we,
  input  logic [abits-1:0]  a_addr,
  input  logic [dbits-1:0]  a_wdata,
  output logic              a_gnt,
  output logic              a_ack,
  output logic [dbits-1:0]  a_rdata,
  input  logic              b_req,
  input  logic [dbytes-1:0] b_we,
  input  logic [abits-1:0]  b_addr,
  input  logic [dbits-1:0]  b_wdata,
  output logic              b_gnt,
  output logic              b_ack,
  output logic [dbits-1:0]  b_rdata,
  output logic              init_done,
  output logic [dbytes-1:0] ram_we,
  output logic [abits-1:0]  ram_addr,
  output logic [dbits-1:0]  ram_wdata,
  input  logic [dbits-1:0]  ram_rdata
);

  logic [1:0]       w_gnt;
  logic             w_clearing;
  logic [abits-1:0] w_clr_addr;
  logic             r_a_ack;
  logic             r_b_ack;

`ifdef BRAM_ARB_CLEAR_EN
  clr_state_t       r_state;
  clr_state_t       w_state_nxt;
  logic [abits-1:0] r_clr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) begin
        r_clr_cnt <= r_clr_cnt + abits'(1);
      end
    end
  end

  // Leave CLEAR once the last address has been written.
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == ST_CLEAR) && (r_clr_cnt == {abits{1'b1}})) begin
      w_state_nxt = ST_RUN;
    end
  end

  always_comb begin
    w_clearing = 1'b0;
    init_done  = 1'b0;
    w_clr_addr = r_clr_cnt;
    case (r_state)
      ST_CLEAR: w_clearing = 1'b1;
      ST_RUN:   init_done  = 1'b1;
      default:  w_clearing = 1'b0;
    endcase
  end
`else
  assign w_clearing = 1'b0;
  assign w_clr_addr = '0;
  assign init_done  = 1'b1;
`endif

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({b_req, a_req}),
    .en  (init_done),
    .gnt (w_gnt)
  );

  assign a_gnt = w_gnt[0];
  assign b_gnt = w_gnt[1];

  // RAM port mux: clear sweep, granted requester, or idle zeros.
  always_comb begin
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (w_clearing) begin
      ram_we   = '1;
      ram_addr = w_clr_addr;
    end else if (w_gnt[0]) begin
      ram_we    = a_we;
      ram_addr  = a_addr;
      ram_wdata = a_wdata;
    end else if (w_gnt[1]) begin
      ram_we    = b_we;
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
    end else begin
      r_a_ack <= w_gnt[0];
      r_b_ack <= w_gnt[1];
    end
  end

  assign a_ack   = r_a_ack;
  assign b_ack   = r_b_ack;
  assign a_rdata = ram_rdata;
  assign b_rdata = ram_rdata;

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter with a read-first RAM model and a shadow-memory reference.
module tb_bram_arbiter;

  localparam int unsigned AB = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, b_req;
  logic [DB-1:0] a_we, b_we;
  logic [AB-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_ack, b_gnt, b_ack, init_done;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [DB-1:0] ram_we;
  logic [AB-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [NW];
  logic [DW-1:0] shadow [NW];
  logic          preload;
  logic [DW-1:0] seed;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            ref_prio;
  logic          last_ga, last_gb;
  exp_t          qa[$];
  exp_t          qb[$];

  bram_arbiter #(.abits(AB), .dbytes(DB), .blen(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_ack(b_ack), .b_rdata(b_rdata),
    .init_done(init_done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pre_word(input int i);
    return seed ^ (32'(i) * 32'h01010101);
  endfunction

  // Raw single-port RAM: 1-cycle read latency, read-first, byte enables.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NW; i++) mem[i] <= pre_word(i);
    end else begin
      ram_rdata <= mem[ram_addr];
      for (int j = 0; j < DB; j++)
        if (ram_we[j]) mem[ram_addr][8*j +: 8] <= ram_wdata[8*j +: 8];
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack pops the expected word queued at grant time.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && a_ack) begin
      if (qa.size() == 0) chk("a_ack_spurious", 32'(a_ack), 32'd0);
      else begin
        e = qa.pop_front();
        chk("a_rdata", a_rdata, e.data);
        chk("a_ack_latency", 32'(cyc), 32'(e.cyc + 1));
      end
    end
    if (!rst && b_ack) begin
      if (qb.size() == 0) chk("b_ack_spurious", 32'(b_ack), 32'd0);
      else begin
        e = qb.pop_front();
        chk("b_rdata", b_rdata, e.data);
        chk("b_ack_latency", 32'(cyc), 32'(e.cyc + 1));
      end
    end
  end

  task automatic apply_write(input logic [AB-1:0] addr, input logic [DB-1:0] we,
                             input logic [DW-1:0] wd);
    for (int j = 0; j < DB; j++)
      if (we[j]) shadow[addr][8*j +: 8] = wd[8*j +: 8];
  endtask

  // One arbitration cycle: predict the grant, check RAM drive, queue the expected ack.
  task automatic cycle(input bit rst_after);
    logic ga, gb;
    logic [DB-1:0] xwe;
    logic [AB-1:0] xaddr;
    logic [DW-1:0] xwd;
    exp_t e;
    @(negedge clk);
    if (a_req && b_req) begin
      ga = (ref_prio == 0);
      gb = !ga;
    end else begin
      ga = a_req;
      gb = b_req;
    end
    xwe = '0; xaddr = '0; xwd = '0;
    if (ga) begin xwe = a_we; xaddr = a_addr; xwd = a_wdata; end
    if (gb) begin xwe = b_we; xaddr = b_addr; xwd = b_wdata; end
    chk("a_gnt", 32'(a_gnt), 32'(ga));
    chk("b_gnt", 32'(b_gnt), 32'(gb));
    chk("ram_we", 32'(ram_we), 32'(xwe));
    chk("ram_addr", 32'(ram_addr), 32'(xaddr));
    chk("ram_wdata", ram_wdata, xwd);
    if (ga || gb) begin
      e.data = shadow[xaddr];
      e.cyc  = cyc;
      if (ga) qa.push_back(e);
      else    qb.push_back(e);
      apply_write(xaddr, xwe, xwd);
      ref_prio = ga ? 1 : 0;
    end
    last_ga = ga;
    last_gb = gb;
    if (rst_after) begin
      rst = 1'b1;
      qa.delete();
      qb.delete();
      ref_prio = 0;
    end
    @(posedge clk);
    #1;
    if (ga) a_req = 1'b0;
    if (gb) b_req = 1'b0;
  endtask

  // Clear sweep: one address per cycle, no grants, init_done after the last one.
  task automatic clear_check(input int abort_at);
    for (int k = 0; k < int'(NW); k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        abort_at = -1;
        k = -1;
        continue;
      end
      chk("clr_init_done", 32'(init_done), 32'd0);
      chk("clr_ram_we", 32'(ram_we), 32'hF);
      chk("clr_ram_addr", 32'(ram_addr), 32'(k));
      chk("clr_ram_wdata", ram_wdata, 32'd0);
      chk("clr_gnt", 32'({b_gnt, a_gnt}), 32'd0);
    end
    @(negedge clk);
    chk("init_done_rise", 32'(init_done), 32'd1);
    for (int i = 0; i < int'(NW); i++) shadow[i] = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic finish_reset();
    qa.delete();
    qb.delete();
    ref_prio = 0;
`ifdef BRAM_ARB_CLEAR_EN
    clear_check(-1);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ack", 32'({b_ack, a_ack}), 32'd0);
    rst = 1'b0;
    finish_reset();
  endtask

  task automatic set_a(input logic [DB-1:0] we, input logic [AB-1:0] addr, input logic [DW-1:0] wd);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic set_b(input logic [DB-1:0] we, input logic [AB-1:0] addr, input logic [DW-1:0] wd);
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    seed = $urandom;
    for (int i = 0; i < int'(NW); i++) shadow[i] = pre_word(i);
    ref_prio = 0;
    rst = 1'b1; preload = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    chk("reset_a_ack", 32'(a_ack), 32'd0);
    chk("reset_b_ack", 32'(b_ack), 32'd0);
`ifdef BRAM_ARB_CLEAR_EN
    chk("reset_init_done", 32'(init_done), 32'd0);
`else
    chk("reset_init_done", 32'(init_done), 32'd1);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    set_a(4'h0, 4'd15, 32'd0);
`ifdef BRAM_ARB_CLEAR_EN
    clear_check(7);
`endif
    cycle(0);
    chk("rd15_ack", 32'(a_ack), 32'd1);
    chk("rd15_data", a_rdata, shadow[15]);
`ifdef BRAM_ARB_CLEAR_EN
    chk("rd15_cleared", a_rdata, 32'd0);
`endif

    // Write then read back on port A.
    set_a(4'hF, 4'd3, 32'hDEADBEEF);
    cycle(0);
    set_a(4'h0, 4'd3, 32'd0);
    cycle(0);
    chk("t1_ack", 32'(a_ack), 32'd1);
    chk("t1_rdata", a_rdata, 32'hDEADBEEF);

    // Continuous contention from reset alternates starting with A.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_a(4'h0, 4'd1, 32'd0);
      set_b(4'h0, 4'd2, 32'd0);
      cycle(0);
      chk("t2_seq_a", 32'(last_ga), 32'((i % 2) == 0));
    end
    a_req = 0; b_req = 0;
    cycle(0);

    // Byte-masked write on port B.
    set_b(4'hF, 4'd5, 32'hAABBCCDD);
    cycle(0);
    set_b(4'b0101, 4'd5, 32'h11223344);
    cycle(0);
    set_b(4'h0, 4'd5, 32'd0);
    cycle(0);
    chk("t3_ack", 32'(b_ack), 32'd1);
    chk("t3_rdata", b_rdata, 32'hAA22CC44);
    cycle(0);

    // Reset right behind a grant discards the ack.
    set_a(4'h0, 4'd7, 32'd0);
    cycle(1);
    chk("t4_ack_dropped", 32'(a_ack), 32'd0);
    @(posedge clk);
    #1;
    chk("t4_ack_still0", 32'(a_ack), 32'd0);
    rst = 1'b0;
    finish_reset();
    chk("t4_post_ack", 32'(a_ack), 32'd0);
    set_a(4'h0, 4'd8, 32'd0);
    set_b(4'h0, 4'd9, 32'd0);
    cycle(0);
    chk("t4_first_a", 32'(last_ga), 32'd1);
    cycle(0);
    chk("t4_then_b", 32'(last_gb), 32'd1);

    // B alone three times, then contention goes to A.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_b(4'h0, 4'(i), 32'd0);
      cycle(0);
      chk("t5_b_alone", 32'(last_gb), 32'd1);
    end
    set_a(4'h0, 4'd4, 32'd0);
    set_b(4'h0, 4'd6, 32'd0);
    cycle(0);
    chk("t5_a_first", 32'(last_ga), 32'd1);
    cycle(0);

    // Random traffic with hold-until-grant and occasional early drop.
    for (int n = 0; n < 400; n++) begin
      if (!a_req) begin
        if ($urandom_range(9) < 6)
          set_a(($urandom_range(1) == 1) ? 4'($urandom) : 4'h0, 4'($urandom), $urandom);
      end else if ($urandom_range(15) == 0) a_req = 1'b0;
      if (!b_req) begin
        if ($urandom_range(9) < 6)
          set_b(($urandom_range(1) == 1) ? 4'($urandom) : 4'h0, 4'($urandom), $urandom);
      end else if ($urandom_range(15) == 0) b_req = 1'b0;
      cycle(0);
    end
    a_req = 0; b_req = 0;
    cycle(0);
    cycle(0);
    @(negedge clk);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
